// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the helpers that size the digit counter.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of digits (and therefore RUN cycles) in one operation.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; a single-digit adder still needs one bit.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// DIGIT-bit ripple-carry adder built from full adders. Purely
// combinational; the digit-serial adder reuses one instance every cycle.
module rca_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock,
// least significant digit first, through one shared rca_slice. The carry
// between digits lives only in r_carry.
//
// Optional feature macro: SUBTRACT_EN adds the 'sub' port. With sub=1 at
// accept, y is inverted as it is captured and the carry is seeded with 1,
// giving {c_out,s} = x - y (c_out=1 means no borrow).
//
// state   | meaning
// IDLE    | waiting for start; s/c_out hold the last result
// RUN     | one digit added per cycle, NDIG cycles
// DONE    | one-cycle done pulse; start here chains the next operation
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_y_load;
  logic             w_ci_load;
  logic [DIGIT-1:0] w_slice_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_step   = (r_state == ST_RUN);
  assign w_last   = w_step && (r_cnt == LAST_DIG);

  // Operand B and the initial carry as they are captured; subtraction
  // stores ~y so the slice itself never needs to know about sub.
  always_comb begin
    w_y_load  = y;
    w_ci_load = c_in;
`ifdef SUBTRACT_EN
    if (sub) begin
      w_y_load  = ~y;
      w_ci_load = 1'b1;
    end
`endif
  end

  rca_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a  (r_x[DIGIT-1:0]),
    .b  (r_y[DIGIT-1:0]),
    .ci (r_carry),
    .sum(w_slice_sum),
    .co (w_co)
  );

  // The partial sum keeps only the digits already finished; the digit
  // being added this cycle is appended on top, so the complete sum is
  // available combinationally on the final RUN edge.
  if (DIGIT < WIDTH) begin : g_acc
    logic [WIDTH-DIGIT-1:0] r_acc;

    // Shift each finished digit in from the top of the partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= '0;
      end else if (w_step) begin
        r_acc <= w_sum_next[WIDTH-1:DIGIT];
      end
    end

    assign w_sum_next = {w_slice_sum, r_acc};
  end else begin : g_no_acc
    assign w_sum_next = w_slice_sum;
  end

  // Working operands, inter-digit carry and digit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_x     <= x;
      r_y     <= w_y_load;
      r_carry <= w_ci_load;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_x     <= r_x >> DIGIT;
      r_y     <= r_y >> DIGIT;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_c_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_s     <= w_sum_next;
            r_c_out <= w_co;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign s     = r_s;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: 16/4 main instance plus three 4-bit
// instances (DIGIT=1, 2, 4) for an exhaustive sweep. Honours SUBTRACT_EN.
module tb_digit_serial_adder;

`ifdef SUBTRACT_EN
  localparam int NSB = 2;
`else
  localparam int NSB = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        c_in;
`ifdef SUBTRACT_EN
  logic        sub;
  logic        w_sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        c_out;

  logic       w_start;
  logic [3:0] w_x;
  logic [3:0] w_y;
  logic       w_ci;
  logic       d1_busy, d1_done, d1_c;
  logic [3:0] d1_s;
  logic       d2_busy, d2_done, d2_c;
  logic [3:0] d2_s;
  logic       d4_busy, d4_done, d4_c;
  logic [3:0] d4_s;

  int total = 0;
  int bad   = 0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .c_in(c_in),
`ifdef SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .c_out(c_out)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(w_start), .x(w_x), .y(w_y), .c_in(w_ci),
`ifdef SUBTRACT_EN
    .sub(w_sub),
`endif
    .busy(d1_busy), .done(d1_done), .s(d1_s), .c_out(d1_c)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(2)) dut_d2 (
    .clk(clk), .rst(rst), .start(w_start), .x(w_x), .y(w_y), .c_in(w_ci),
`ifdef SUBTRACT_EN
    .sub(w_sub),
`endif
    .busy(d2_busy), .done(d2_done), .s(d2_s), .c_out(d2_c)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .start(w_start), .x(w_x), .y(w_y), .c_in(w_ci),
`ifdef SUBTRACT_EN
    .sub(w_sub),
`endif
    .busy(d4_busy), .done(d4_done), .s(d4_s), .c_out(d4_c)
  );

  // Reference: plain integer arithmetic on the (WIDTH+1)-bit result.
  function automatic int ref_model(input int w, input int a, input int b,
                                   input int ci, input int sb);
    int r;
    if (sb != 0) r = a - b + (1 << w);
    else         r = a + b + ci;
    return r & ((1 << (w + 1)) - 1);
  endfunction

  task automatic launch(input logic [15:0] xv, input logic [15:0] yv, input logic civ);
    @(posedge clk); #1;
    x = xv; y = yv; c_in = civ; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle after the accepting edge; lat=-1 on timeout.
  task automatic wait_done(output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    int seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL reset_s got=%h want=0000", s); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out got=%b want=0", c_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL idle_activity got=%0d want=0", seen); end
  endtask

  task automatic test_carry_wrap;
    int lat, nb;
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat, nb);
    total++; if (lat != 5) begin bad++; $display("FAIL wrap_latency got=%0d want=5", lat); end
    total++; if (nb != 4) begin bad++; $display("FAIL wrap_busy_cycles got=%0d want=4", nb); end
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL wrap_s got=%h want=0000", s); end
    total++; if (c_out !== 1'b1) begin bad++; $display("FAIL wrap_c_out got=%b want=1", c_out); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", done); end
    total++; if ({c_out, s} !== 17'h10000) begin bad++; $display("FAIL wrap_hold got=%h want=10000", {c_out, s}); end
  endtask

  task automatic test_change_during_run;
    int lat, nb;
    @(posedge clk); #1;
    x = 16'h1234; y = 16'h4321; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 16'($urandom); y = 16'($urandom); c_in = 1'b0;
    wait_done(lat, nb);
    total++; if (lat != 5) begin bad++; $display("FAIL chg_latency got=%0d want=5", lat); end
    total++; if ({c_out, s} !== 17'h05556) begin bad++; $display("FAIL chg_result got=%h want=05556", {c_out, s}); end
  endtask

  task automatic test_random;
    int lat, nb, sb;
    logic [15:0] xv, yv;
    logic civ;
    logic [16:0] exp_r;
    for (int i = 0; i < 25; i++) begin
      xv = 16'($urandom);
      yv = 16'($urandom);
      civ = 1'($urandom);
      sb = 0;
`ifdef SUBTRACT_EN
      sb = int'($urandom_range(0, 1));
      sub = sb[0];
`endif
      exp_r = 17'(ref_model(16, int'(xv), int'(yv), int'(civ), sb));
      launch(xv, yv, civ);
      wait_done(lat, nb);
      total++; if (lat != 5) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=5", i, lat); end
      total++; if ({c_out, s} !== exp_r) begin bad++; $display("FAIL rand_result[%0d] got=%h want=%h", i, {c_out, s}, exp_r); end
    end
`ifdef SUBTRACT_EN
    sub = 1'b0;
`endif
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    logic [15:0] av, bv;
    logic [16:0] exp_r;
    av = 16'($urandom);
    bv = 16'($urandom);
    exp_r = 17'(ref_model(16, int'(av), int'(bv), 0, 0));
    @(posedge clk); #1;
    x = av; y = bv; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    x = 16'h0001; y = 16'h0001;
    wait_done(lat, nb);
    total++; if (lat != 5) begin bad++; $display("FAIL b2b_first_latency got=%0d want=5", lat); end
    total++; if ({c_out, s} !== exp_r) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", {c_out, s}, exp_r); end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nb);
    total++; if (lat != 5) begin bad++; $display("FAIL b2b_second_latency got=%0d want=5", lat); end
    total++; if (nb != 4) begin bad++; $display("FAIL b2b_second_busy got=%0d want=4", nb); end
    total++; if ({c_out, s} !== 17'h00002) begin bad++; $display("FAIL b2b_second_result got=%h want=00002", {c_out, s}); end
  endtask

  task automatic test_reset_mid_run;
    int lat, nb, seen;
    logic [15:0] av, bv;
    logic [16:0] exp_r;
    launch(16'($urandom), 16'($urandom), 1'b1);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b want=1", busy); end
    total++; if ({c_out, s} !== 17'h00002) begin bad++; $display("FAIL hold_in_run got=%h want=00002", {c_out, s}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_activity got=%0d want=0", seen); end
    total++; if ({c_out, s} !== 17'h00000) begin bad++; $display("FAIL abort_result got=%h want=00000", {c_out, s}); end
    av = 16'($urandom);
    bv = 16'($urandom);
    exp_r = 17'(ref_model(16, int'(av), int'(bv), 0, 0));
    launch(av, bv, 1'b0);
    wait_done(lat, nb);
    total++; if (lat != 5) begin bad++; $display("FAIL after_abort_latency got=%0d want=5", lat); end
    total++; if ({c_out, s} !== exp_r) begin bad++; $display("FAIL after_abort_result got=%h want=%h", {c_out, s}, exp_r); end
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract;
    int lat, nb;
    sub = 1'b1;
    launch(16'h0005, 16'h0007, 1'b1);
    sub = 1'b0;
    wait_done(lat, nb);
    total++; if (lat != 5) begin bad++; $display("FAIL sub_latency got=%0d want=5", lat); end
    total++; if ({c_out, s} !== 17'h0FFFE) begin bad++; $display("FAIL sub_result got=%h want=0fffe", {c_out, s}); end
  endtask
`endif

  task automatic test_sweep;
    int l1, l2, l4;
    logic [4:0] g1, g2, g4, e;
    for (int xv = 0; xv < 16; xv++) begin
      for (int yv = 0; yv < 16; yv++) begin
        for (int ci = 0; ci < 2; ci++) begin
          for (int sb = 0; sb < NSB; sb++) begin
            @(posedge clk); #1;
            w_x = 4'(xv); w_y = 4'(yv); w_ci = ci[0]; w_start = 1'b1;
`ifdef SUBTRACT_EN
            w_sub = sb[0];
`endif
            @(posedge clk); #1;
            w_start = 1'b0;
            l1 = -1; l2 = -1; l4 = -1;
            g1 = '0; g2 = '0; g4 = '0;
            for (int k = 1; k <= 8; k++) begin
              @(negedge clk);
              if (d1_done && l1 < 0) begin l1 = k; g1 = {d1_c, d1_s}; end
              if (d2_done && l2 < 0) begin l2 = k; g2 = {d2_c, d2_s}; end
              if (d4_done && l4 < 0) begin l4 = k; g4 = {d4_c, d4_s}; end
            end
            e = 5'(ref_model(4, xv, yv, ci, sb));
            total++; if (l1 != 5) begin bad++; $display("FAIL sweep_d1_latency x=%0d y=%0d ci=%0d sub=%0d got=%0d want=5", xv, yv, ci, sb, l1); end
            total++; if (g1 !== e) begin bad++; $display("FAIL sweep_d1_result x=%0d y=%0d ci=%0d sub=%0d got=%h want=%h", xv, yv, ci, sb, g1, e); end
            total++; if (l2 != 3) begin bad++; $display("FAIL sweep_d2_latency x=%0d y=%0d ci=%0d sub=%0d got=%0d want=3", xv, yv, ci, sb, l2); end
            total++; if (g2 !== e) begin bad++; $display("FAIL sweep_d2_result x=%0d y=%0d ci=%0d sub=%0d got=%h want=%h", xv, yv, ci, sb, g2, e); end
            total++; if (l4 != 2) begin bad++; $display("FAIL sweep_d4_latency x=%0d y=%0d ci=%0d sub=%0d got=%0d want=2", xv, yv, ci, sb, l4); end
            total++; if (g4 !== e) begin bad++; $display("FAIL sweep_d4_result x=%0d y=%0d ci=%0d sub=%0d got=%h want=%h", xv, yv, ci, sb, g4, e); end
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    c_in = 1'b0;
    w_start = 1'b0;
    w_x = '0;
    w_y = '0;
    w_ci = 1'b0;
`ifdef SUBTRACT_EN
    sub = 1'b0;
    w_sub = 1'b0;
`endif
    test_reset;
    test_carry_wrap;
    test_change_during_run;
    test_random;
    test_back_to_back;
    test_reset_mid_run;
`ifdef SUBTRACT_EN
    test_subtract;
`endif
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
